serial_pattern_gen: RTL
=======================

Name: serial_pattern_gen

Overview:
- Serial bit-stream transmitter: emits a programmable N-bit pattern one bit per clock, MSB first, repeated a requested number of times with a fixed idle gap between frames.
- Serves as the stimulus/transmit end for the team's serial sequence detectors. It drives the single-bit line those detectors sample on every clock.
- A start pulse launches a burst. A done pulse reports completion.

Parameters:
- PAT_W, 3, pattern width in bits (>=1).
- REP_W, 4, width of the repeat-count input.
- GAP_CYCLES, 2, idle-level bits inserted between consecutive frames (0 = back-to-back frames).
- IDLE_BIT, 1'b1, line level driven whenever no pattern bit is being sent.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  launch request; sampled only in IDLE.
- pattern  input  PAT_W  pattern to send; latched on accepted start.
- repeat_cnt  input  REP_W  number of frames; latched on accepted start; 0 is treated as 1.
- out  output  1  serial line, registered.
- out_valid  output  1  high while out carries a pattern bit.
- frame_start  output  1  one-cycle pulse coincident with the MSB of each frame.
- busy  output  1  high from accepted start through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- Reset: rst_n=0 at a rising edge returns the block to IDLE.
  - Outputs after reset: out=IDLE_BIT, out_valid=0, frame_start=0, busy=0, done=0.
  - Internal pattern, bit index, repeat and gap counters are cleared.
  - Applies from any state, including mid-frame. The partial frame is abandoned and no done pulse is issued.
- All outputs are registered. A start sampled at edge E produces the first pattern bit on out in the cycle following E.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - out=IDLE_BIT, out_valid=0, busy=0.
  - start=1 at an edge: latch pattern into pat_q; set reps_left = max(repeat_cnt,1); set bit_idx=PAT_W-1.
  - Same edge drives out=pattern[PAT_W-1], out_valid=1, frame_start=1, busy=1, and moves to SHIFT.
- SHIFT, each edge:
  - If bit_idx>0: decrement bit_idx and drive out=pat_q[bit_idx-1], frame_start=0.
  - If bit_idx==0 and reps_left>1: decrement reps_left.
    - GAP_CYCLES>0: go to GAP with gap counter = GAP_CYCLES, out=IDLE_BIT, out_valid=0.
    - GAP_CYCLES=0: start the next frame directly (bit_idx=PAT_W-1, out=pat_q[PAT_W-1], frame_start=1).
  - If bit_idx==0 and reps_left==1: go to DONE with out=IDLE_BIT, out_valid=0, done=1.
- GAP:
  - out=IDLE_BIT, out_valid=0 for exactly GAP_CYCLES cycles.
  - On the last gap cycle's edge, start the next frame as above.
- DONE:
  - Lasts exactly one cycle with done=1, busy=1.
  - Next edge goes to IDLE with done=0, busy=0.
- start while in SHIFT, GAP or DONE is ignored: no queuing, and pattern/repeat_cnt changes have no effect.
  - start re-sampled in IDLE is accepted on the first IDLE cycle. Minimum spacing between bursts is therefore one IDLE cycle after DONE.
- Frame timing: each frame is exactly PAT_W consecutive valid cycles.
- Total burst length, start edge to done pulse: R*PAT_W + (R-1)*GAP_CYCLES cycles, then one DONE cycle. R is the effective repeat count.
- PAT_W=1: every frame is a single cycle with frame_start=1.
- Counters sized so that REP_W all-ones and GAP_CYCLES up to 255 do not wrap.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles mid-idle -> out=1, out_valid=0, busy=0, done=0; release, no activity without start.
- Single frame: pattern=3'b011, repeat_cnt=1, start at edge 0 -> out=0,1,1 with out_valid=1 in cycles 1-3; frame_start only in cycle 1; done=1 in cycle 4; busy=0 from cycle 5.
- Repeat with gap: GAP_CYCLES=2, pattern=3'b011, repeat_cnt=2 -> serial 0,1,1,1,1,0,1,1 with out_valid 1,1,1,0,0,1,1,1; frame_start in cycles 1 and 6; done in cycle 9.
- Zero repeat and ignored start: repeat_cnt=0 -> exactly one frame. Pulse start again with pattern=3'b100 during SHIFT -> ignored; stream unchanged, single done pulse.
- Reset mid-operation: rst_n=0 at the second bit of a 3-frame burst -> next cycle out=1, out_valid=0, busy=0, no done pulse; a new start afterwards sends a full burst correctly.
- Back-to-back: GAP_CYCLES=0, pattern=3'b101, repeat_cnt=3 -> nine contiguous valid bits 101101101; frame_start in cycles 1, 4, 7; done in cycle 10.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// repeated R times with GAP_CYCLES idle-level bits between frames.
module serial_pattern_gen #(
  parameter int unsigned PAT_W      = 3,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               launch_c;

  // State and datapath register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      bit_idx_q     <= '0;
      reps_q        <= '0;
      gap_q         <= '0;
      out_q         <= IDLE_BIT;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      bit_idx_q     <= bit_idx_d;
      reps_q        <= reps_d;
      gap_q         <= gap_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next state and counters; launch_c marks the edge that begins a frame
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    bit_idx_d = bit_idx_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    launch_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          reps_d    = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
          bit_idx_d = LAST_IDX;
          launch_c  = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end else if (reps_q > REP_W'(1)) begin
          reps_d = reps_q - REP_W'(1);
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = S_GAP;
          end else begin
            bit_idx_d = LAST_IDX;
            launch_c  = 1'b1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d     = '0;
          bit_idx_d = LAST_IDX;
          launch_c  = 1'b1;
          state_d   = S_SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    out_d         = IDLE_BIT;
    out_valid_d   = 1'b0;
    frame_start_d = launch_c;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    if (state_d == S_SHIFT) begin
      out_d       = pat_d[bit_idx_d];
      out_valid_d = 1'b1;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
